ctrl_pipe_hazard: RTL
=====================

# ctrl_pipe_hazard

Pipelines the control bundle produced by the main control unit through the ID/EX, EX/MEM and MEM/WB stages of the 5-stage RV32 core. It detects load-use and control hazards, inserts bubbles, flushes wrong-path instructions, and drives the PC select. It also generates EX-stage operand-forwarding selects. It sits between the decode stage and the datapath stage registers and consumes the decoder's outputs cycle by cycle.

## Interface
- No parameters; register index width is fixed at 5.
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2, id_rd  in  5 each  ID-stage register indices
- id_ALUop  in  2; id_ALUSrc, id_branch, id_jump, id_memRead, id_memWrite, id_memToReg, id_regWrite  in  1 each  decoder control bundle
- ex_zero  in  1  ALU zero flag for the instruction in EX
- ex_ALUop  out  2; ex_ALUSrc, ex_branch, ex_jump, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite  out  1 each; ex_rs1, ex_rs2, ex_rd  out  5  ID/EX register
- mem_memRead, mem_memWrite, mem_memToReg, mem_regWrite  out  1; mem_rd  out  5  EX/MEM register
- wb_memToReg, wb_regWrite  out  1; wb_rd  out  5  MEM/WB register
- pc_write  out  1  PC enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  clear IF/ID
- pc_sel  out  2  00 = PC+4, 01 = jump target, 10 = branch target
- fwd_a, fwd_b  out  2  EX operand source: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB

## Operation
- Bubble: all control bits 0 and all indices 0.
- redirect = ex_jump | (ex_branch & ex_zero).
  - pc_sel = 01 if ex_jump, else 10 if the branch is taken, else 00.
- load_use = ex_memRead & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority: redirect over stall.
  - On redirect: ifid_flush=1, pc_write=1, ifid_write=1; a bubble is loaded into ID/EX; load_use is ignored because the ID instruction is wrong-path.
  - Else on stall: pc_write=0, ifid_write=0, ifid_flush=0; a bubble is loaded into ID/EX.
  - Else: pc_write=1, ifid_write=1, ifid_flush=0; ID/EX loads the id_* bundle, or a bubble if id_valid=0.
- EX/MEM always loads the relevant ID/EX fields, and MEM/WB always loads from EX/MEM. There is no back-pressure downstream of EX.
- Forwarding, computed from the current registers:
  - fwd_a = 10 if mem_regWrite & mem_rd≠0 & mem_rd==ex_rs1.
  - Otherwise fwd_a = 01 if wb_regWrite & wb_rd≠0 & wb_rd==ex_rs1.
  - Otherwise fwd_a = 00.
  - fwd_b is computed the same way using ex_rs2. EX/MEM wins when both stages match.
- Register x0 never causes a stall or a forward.

## Timing
- All hazard, forwarding and pc_sel outputs are combinational from the current stage registers and the ID inputs, within the same cycle.
- Stage registers have 1-cycle latency: a bundle accepted in ID appears on ex_* next cycle, mem_* after 2 cycles, and wb_* after 3.
- A load-use stall lasts exactly 1 cycle; the following cycle the load sits in MEM and the dependency is resolved by forwarding.
- A redirect costs 2 bubbles: the IF/ID flush plus the ID/EX bubble.
- Reset (asynchronous, any cycle, including mid-stall or mid-redirect): all stage registers are set to bubble.
  - While rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, pc_sel=00, fwd_a=fwd_b=00.
  - The first rising edge after deassertion performs normal operation.
- Redirect and load_use in the same cycle: the redirect is taken with no stall.

## Configuration
- HAZARD_FWD_EN defined: forwarding is as described, and only load-use hazards stall.
- HAZARD_FWD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - stall = id_valid & a RAW match of id_rs1/id_rs2 against ex_rd (when ex_regWrite) or mem_rd (when mem_regWrite), with rd≠0.
  - The register file is write-first, so WB needs no stall.
  - Stall and redirect rules are otherwise unchanged.

## Test plan
- Reset then idle:
  - While rst_n=0: pc_write=0, ifid_flush=1, all ex_/mem_/wb_ fields 0.
  - After release with id_valid=0: pc_write=1, pc_sel=00, stages stay bubbles.
- Load-use: lw x5 (ID/EX memRead=1, rd=5) with ID add rs1=5 → pc_write=0 and ifid_write=0 for 1 cycle; next cycle ex_* is a bubble, then the add enters EX with fwd_a=01.
- Back-to-back ALU (with HAZARD_FWD_EN): add x3, then sub rs2=3 → fwd_b=10 with no stall; with x0 as the rd → fwd_b=00.
- Taken beq (ex_branch=1, ex_zero=1) while ID shows load_use → pc_sel=10, ifid_flush=1, pc_write=1, next ex_* is a bubble; not-taken (ex_zero=0) → pc_sel=00 with no flush.
- Jump in EX → pc_sel=01, flush; ex_regWrite=1 propagates to wb_regWrite 2 cycles later with wb_rd intact.
- HAZARD_FWD_EN undefined: addi x7, then add rs1=7 → 2 stall cycles, fwd_a stays 00; rst_n is pulsed low mid-stall → all stages are bubbles immediately.

Source files
------------

// File: rtl/ctrl_pipe_hazard.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_hazard
//
// Carries the decoder's control bundle through the ID/EX, EX/MEM and MEM/WB
// stage registers of the 5-stage RV32 core. It also resolves pipeline hazards:
//   - a control redirect (jump, or a taken branch in EX) flushes IF/ID, forces
//     a bubble into ID/EX and steers the PC mux;
//   - a data hazard against the instruction in ID holds PC and IF/ID for a
//     cycle and forces a bubble into ID/EX;
//   - EX operand-forwarding selects are derived from the EX/MEM and MEM/WB
//     registers.
//
// Build option (macro HAZARD_FWD_EN):
//   defined   : forwarding from EX/MEM and MEM/WB is active; only a load
//               followed by a dependent instruction stalls (one cycle).
//   undefined : fwd_a/fwd_b are tied to 00; any RAW dependency of ID on the
//               EX or MEM producer stalls until the producer reaches WB
//               (the register file is write-first, so WB needs no stall).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   id_valid                ID stage holds a real instruction
//   id_rs1/id_rs2/id_rd     ID register indices
//   id_ALUop .. id_regWrite decoder control bundle
//   ex_zero                 ALU zero flag of the instruction in EX
//   ex_*                    ID/EX register contents
//   mem_*                   EX/MEM register contents
//   wb_*                    MEM/WB register contents
//   pc_write, ifid_write    PC and IF/ID enables
//   ifid_flush              clear IF/ID
//   pc_sel                  00 PC+4, 01 jump target, 10 branch target
//   fwd_a, fwd_b            EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
// ---------------------------------------------------------------------------
module ctrl_pipe_hazard (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic [1:0] id_ALUop,
  input  logic       id_ALUSrc,
  input  logic       id_branch,
  input  logic       id_jump,
  input  logic       id_memRead,
  input  logic       id_memWrite,
  input  logic       id_memToReg,
  input  logic       id_regWrite,

  input  logic       ex_zero,

  output logic [1:0] ex_ALUop,
  output logic       ex_ALUSrc,
  output logic       ex_branch,
  output logic       ex_jump,
  output logic       ex_memRead,
  output logic       ex_memWrite,
  output logic       ex_memToReg,
  output logic       ex_regWrite,
  output logic [4:0] ex_rs1,
  output logic [4:0] ex_rs2,
  output logic [4:0] ex_rd,

  output logic       mem_memRead,
  output logic       mem_memWrite,
  output logic       mem_memToReg,
  output logic       mem_regWrite,
  output logic [4:0] mem_rd,

  output logic       wb_memToReg,
  output logic       wb_regWrite,
  output logic [4:0] wb_rd,

  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic [1:0] pc_sel,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // -------------------------------------------------------------------------
  // Stage register layouts. An all-zero value of each is a bubble.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } memwb_t;

  idex_t  idex_reg,  idex_next;
  exmem_t exmem_reg, exmem_next;
  memwb_t memwb_reg, memwb_next;

  logic redirect;
  logic stall;

  // -------------------------------------------------------------------------
  // Control redirect, resolved in EX.
  // -------------------------------------------------------------------------
  assign redirect = idex_reg.jump | (idex_reg.branch & ex_zero);

  // -------------------------------------------------------------------------
  // Data-hazard detection against the instruction currently in ID.
  // -------------------------------------------------------------------------
`ifdef HAZARD_FWD_EN
  // With forwarding, only a load in EX cannot supply its result in time.
  logic ex_rd_match;

  assign ex_rd_match = (idex_reg.rd == id_rs1) | (idex_reg.rd == id_rs2);
  assign stall       = idex_reg.mem_read & (idex_reg.rd != 5'd0) &
                       id_valid & ex_rd_match;
`else
  // Without forwarding, any pending write in EX or MEM to a source register
  // of the ID instruction must drain to WB first.
  logic raw_ex;
  logic raw_mem;

  assign raw_ex  = idex_reg.reg_write & (idex_reg.rd != 5'd0) &
                   ((idex_reg.rd == id_rs1) | (idex_reg.rd == id_rs2));
  assign raw_mem = exmem_reg.reg_write & (exmem_reg.rd != 5'd0) &
                   ((exmem_reg.rd == id_rs1) | (exmem_reg.rd == id_rs2));
  assign stall   = id_valid & (raw_ex | raw_mem);
`endif

  // -------------------------------------------------------------------------
  // PC / IF-ID control. While reset is asserted the front end is held and
  // IF/ID is cleared. A redirect takes precedence over a stall because the
  // instruction sitting in ID is on the wrong path.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b1;
    pc_sel     = 2'b00;
    if (rst_n) begin
      if (redirect) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        pc_sel     = idex_reg.jump ? 2'b01 : 2'b10;
      end else if (stall) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state of the stage registers.
  // -------------------------------------------------------------------------
  always_comb begin
    idex_next = '0;
    if (id_valid && !redirect && !stall) begin
      idex_next.alu_op     = id_ALUop;
      idex_next.alu_src    = id_ALUSrc;
      idex_next.branch     = id_branch;
      idex_next.jump       = id_jump;
      idex_next.mem_read   = id_memRead;
      idex_next.mem_write  = id_memWrite;
      idex_next.mem_to_reg = id_memToReg;
      idex_next.reg_write  = id_regWrite;
      idex_next.rs1        = id_rs1;
      idex_next.rs2        = id_rs2;
      idex_next.rd         = id_rd;
    end
  end

  // Nothing downstream of EX ever stalls, so these always advance.
  always_comb begin
    exmem_next            = '0;
    exmem_next.mem_read   = idex_reg.mem_read;
    exmem_next.mem_write  = idex_reg.mem_write;
    exmem_next.mem_to_reg = idex_reg.mem_to_reg;
    exmem_next.reg_write  = idex_reg.reg_write;
    exmem_next.rd         = idex_reg.rd;
  end

  always_comb begin
    memwb_next            = '0;
    memwb_next.mem_to_reg = exmem_reg.mem_to_reg;
    memwb_next.reg_write  = exmem_reg.reg_write;
    memwb_next.rd         = exmem_reg.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_reg  <= '0;
      exmem_reg <= '0;
      memwb_reg <= '0;
    end else begin
      idex_reg  <= idex_next;
      exmem_reg <= exmem_next;
      memwb_reg <= memwb_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stage register outputs.
  // -------------------------------------------------------------------------
  assign ex_ALUop     = idex_reg.alu_op;
  assign ex_ALUSrc    = idex_reg.alu_src;
  assign ex_branch    = idex_reg.branch;
  assign ex_jump      = idex_reg.jump;
  assign ex_memRead   = idex_reg.mem_read;
  assign ex_memWrite  = idex_reg.mem_write;
  assign ex_memToReg  = idex_reg.mem_to_reg;
  assign ex_regWrite  = idex_reg.reg_write;
  assign ex_rs1       = idex_reg.rs1;
  assign ex_rs2       = idex_reg.rs2;
  assign ex_rd        = idex_reg.rd;

  assign mem_memRead  = exmem_reg.mem_read;
  assign mem_memWrite = exmem_reg.mem_write;
  assign mem_memToReg = exmem_reg.mem_to_reg;
  assign mem_regWrite = exmem_reg.reg_write;
  assign mem_rd       = exmem_reg.rd;

  assign wb_memToReg  = memwb_reg.mem_to_reg;
  assign wb_regWrite  = memwb_reg.reg_write;
  assign wb_rd        = memwb_reg.rd;

  // -------------------------------------------------------------------------
  // EX operand forwarding. Operand 0 is rs1 (fwd_a), operand 1 is rs2
  // (fwd_b). The younger producer in EX/MEM wins over MEM/WB.
  // -------------------------------------------------------------------------
`ifdef HAZARD_FWD_EN
  logic [9:0] ex_src_vec;
  logic [3:0] fwd_vec;

  assign ex_src_vec = {idex_reg.rs2, idex_reg.rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [4:0] src;
    logic       hit_mem;
    logic       hit_wb;

    assign src     = ex_src_vec[5*gi +: 5];
    assign hit_mem = exmem_reg.reg_write & (exmem_reg.rd != 5'd0) &
                     (exmem_reg.rd == src);
    assign hit_wb  = memwb_reg.reg_write & (memwb_reg.rd != 5'd0) &
                     (memwb_reg.rd == src);
    assign fwd_vec[2*gi +: 2] = !rst_n  ? 2'b00 :
                                hit_mem ? 2'b10 :
                                hit_wb  ? 2'b01 : 2'b00;
  end

  assign fwd_a = fwd_vec[1:0];
  assign fwd_b = fwd_vec[3:2];
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule
